// File: rtl/regfile_pkg.sv
// Shared opcode and FSM state encodings for the register-file command sequencer.
package regfile_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_MOV  = 2'd1,
        OP_READ = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Command/response bus between a requester and the register-file sequencer.
// Handshake: a beat transfers on a rising clk edge where valid && ready are both
// high; the sender holds valid and its payload stable until that edge.
interface regfile_sequencer_if #(
    parameter int N = 8
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_src;
    logic [N-1:0] cmd_dst;
    logic [N-1:0] cmd_imm;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Turns LOAD/MOV/READ commands into single-cycle register-file read/write pulses
// and returns one response per command.
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_sequencer_if.slave        bus,
    output logic                      rf_write_en,
    output logic                      rf_out_en,
    output logic [N-1:0]              rf_sel,
    output logic [N-1:0]              rf_data_in,
    input  logic [N-1:0]              rf_data_out,
    output state_t                    state
);

    localparam logic [N-1:0] SEL_LIMIT = N'(N);

    op_t          op_q;
    logic [N-1:0] src_q;
    logic [N-1:0] dst_q;
    logic [N-1:0] imm_q;
    logic [N-1:0] data_q;
    logic         rsp_valid_q;
    logic         rsp_err_q;
    logic [N-1:0] rsp_data_q;

    op_t  cmd_op;
    logic accept;
    logic cmd_bad;

    assign cmd_op        = op_t'(bus.cmd_op);
    assign bus.cmd_ready = (state == ST_IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;

    // Only the selects an opcode actually uses are range-checked.
    always_comb begin
        cmd_bad = 1'b0;
        case (cmd_op)
            OP_LOAD: cmd_bad = (bus.cmd_dst >= SEL_LIMIT);
            OP_MOV:  cmd_bad = (bus.cmd_src >= SEL_LIMIT) || (bus.cmd_dst >= SEL_LIMIT);
            OP_READ: cmd_bad = (bus.cmd_src >= SEL_LIMIT);
            default: cmd_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_LOAD;
            src_q       <= '0;
            dst_q       <= '0;
            imm_q       <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= cmd_op;
                        src_q <= bus.cmd_src;
                        dst_q <= bus.cmd_dst;
                        imm_q <= bus.cmd_imm;
                        if (cmd_bad) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else if (cmd_op == OP_LOAD) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    data_q <= rf_data_out;
                    if (op_q == OP_MOV) begin
                        state <= ST_WRITE;
                    end else begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= rf_data_out;
                    end
                end
                ST_WRITE: begin
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= (op_q == OP_LOAD) ? imm_q : data_q;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register-file controls are a pure decode of registered state, so a reset
    // in READ/WRITE drops the enables on the very next cycle.
    always_comb begin
        rf_write_en = 1'b0;
        rf_out_en   = 1'b0;
        rf_sel      = '0;
        rf_data_in  = '0;
        case (state)
            ST_READ: begin
                rf_out_en = 1'b1;
                rf_sel    = src_q;
            end
            ST_WRITE: begin
                rf_write_en = 1'b1;
                rf_sel      = dst_q;
                rf_data_in  = (op_q == OP_LOAD) ? imm_q : data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8-entry register file.
module tb_regfile_sequencer;
    import regfile_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         rf_write_en;
    logic         rf_out_en;
    logic [N-1:0] rf_sel;
    logic [N-1:0] rf_data_in;
    logic [N-1:0] rf_data_out;
    state_t       state;

    regfile_sequencer_if #(.N(N)) bus ();

    regfile_sequencer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rf_write_en (rf_write_en),
        .rf_out_en   (rf_out_en),
        .rf_sel      (rf_sel),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file model: reset preloads Rk = 0x10 + k
    logic [N-1:0] regs [8];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h10 + 8'(i);
        end else if (rf_write_en && rf_sel < 8) begin
            regs[rf_sel[2:0]] <= rf_data_in;
        end
    end
    assign rf_data_out = rf_out_en ? regs[rf_sel[2:0]] : 8'hEE;

    // scoreboard
    logic [N-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) check("rf_excl", 8'(rf_write_en & rf_out_en), 8'd0);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] src, input logic [7:0] dst,
                        input logic [7:0] imm, input logic [7:0] exp_data);
        check("cmd_ready_before_send", 8'(bus.cmd_ready), 8'd1);
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        exp_q.push_back(exp_data);
        step();
        bus.cmd_valid = 1'b0;
        check("cmd_ready_after_accept", 8'(bus.cmd_ready), 8'd0);
    endtask

    task automatic consume();
        check("rsp_valid_at_consume", 8'(bus.rsp_valid), 8'd1);
        check("cmd_ready_in_resp", 8'(bus.cmd_ready), 8'd0);
        check("sb_nonempty", 8'(exp_q.size() > 0), 8'd1);
        if (exp_q.size() > 0) check("sb_rsp_data", bus.rsp_data, exp_q.pop_front());
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("idle_after_rsp", 8'(state), 8'(ST_IDLE));
        check("rsp_valid_cleared", 8'(bus.rsp_valid), 8'd0);
        check("cmd_ready_after_rsp", 8'(bus.cmd_ready), 8'd1);
    endtask

    task automatic expect_err();
        check("err_state", 8'(state), 8'(ST_RESP));
        check("err_rsp_valid", 8'(bus.rsp_valid), 8'd1);
        check("err_flag", 8'(bus.rsp_err), 8'd1);
        check("err_data", bus.rsp_data, 8'h00);
        check("err_no_wr", 8'(rf_write_en), 8'd0);
        check("err_no_rd", 8'(rf_out_en), 8'd0);
        consume();
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_src   = '0;
        bus.cmd_dst   = '0;
        bus.cmd_imm   = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();

        // reset state
        check("rst_cmd_ready", 8'(bus.cmd_ready), 8'd0);
        check("rst_state", 8'(state), 8'(ST_IDLE));
        check("rst_rsp_valid", 8'(bus.rsp_valid), 8'd0);
        check("rst_rsp_err", 8'(bus.rsp_err), 8'd0);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        check("rst_wr", 8'(rf_write_en), 8'd0);
        check("rst_sel", rf_sel, 8'h00);
        rst = 1'b0;
        #1;
        check("release_cmd_ready", 8'(bus.cmd_ready), 8'd1);

        // LOAD dst=3 imm=A5
        send(2'd0, 8'h00, 8'h03, 8'hA5, 8'hA5);
        check("load_state", 8'(state), 8'(ST_WRITE));
        check("load_wr", 8'(rf_write_en), 8'd1);
        check("load_sel", rf_sel, 8'h03);
        check("load_din", rf_data_in, 8'hA5);
        check("load_rsp_early", 8'(bus.rsp_valid), 8'd0);
        step();
        check("load_wr_off", 8'(rf_write_en), 8'd0);
        check("load_sel_off", rf_sel, 8'h00);
        check("load_din_off", rf_data_in, 8'h00);
        check("load_err", 8'(bus.rsp_err), 8'd0);
        consume();
        check("load_reg3", regs[3], 8'hA5);

        // MOV src=3 dst=0
        send(2'd1, 8'h03, 8'h00, 8'h77, 8'hA5);
        check("mov_state_rd", 8'(state), 8'(ST_READ));
        check("mov_rd", 8'(rf_out_en), 8'd1);
        check("mov_rd_sel", rf_sel, 8'h03);
        step();
        check("mov_state_wr", 8'(state), 8'(ST_WRITE));
        check("mov_wr", 8'(rf_write_en), 8'd1);
        check("mov_wr_sel", rf_sel, 8'h00);
        check("mov_wr_din", rf_data_in, 8'hA5);
        check("mov_rsp_early", 8'(bus.rsp_valid), 8'd0);
        step();
        check("mov_err", 8'(bus.rsp_err), 8'd0);
        consume();
        check("mov_reg0", regs[0], 8'hA5);

        // READ src=0 confirms the MOV landed
        send(2'd2, 8'h00, 8'h05, 8'h00, 8'hA5);
        check("rd0_sel", rf_sel, 8'h00);
        step();
        consume();

        // READ src=1 under 5 cycles of backpressure
        send(2'd2, 8'h01, 8'h00, 8'h00, 8'h11);
        check("bp_rd", 8'(rf_out_en), 8'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 8'(bus.rsp_valid), 8'd1);
            check("bp_data", bus.rsp_data, 8'h11);
            check("bp_err", 8'(bus.rsp_err), 8'd0);
            check("bp_cmd_ready", 8'(bus.cmd_ready), 8'd0);
            step();
        end
        consume();

        // READ of the highest legal select
        send(2'd2, 8'h07, 8'h00, 8'h00, 8'h17);
        step();
        consume();

        // MOV with src == dst
        send(2'd1, 8'h02, 8'h02, 8'h00, 8'h12);
        check("self_rd_sel", rf_sel, 8'h02);
        step();
        check("self_wr", 8'(rf_write_en), 8'd1);
        check("self_din", rf_data_in, 8'h12);
        step();
        consume();
        check("self_reg2", regs[2], 8'h12);

        // rejected commands
        send(2'd0, 8'h00, 8'h08, 8'h5A, 8'h00);
        expect_err();
        send(2'd3, 8'h00, 8'h00, 8'h5A, 8'h00);
        expect_err();
        send(2'd1, 8'h09, 8'h01, 8'h00, 8'h00);
        expect_err();
        check("err_reg1_intact", regs[1], 8'h11);

        // reset during MOV WRITE discards the response
        bus.cmd_op    = 2'd1;
        bus.cmd_src   = 8'h01;
        bus.cmd_dst   = 8'h05;
        bus.cmd_valid = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        check("rstw_in_write", 8'(rf_write_en), 8'd1);
        rst = 1'b1;
        step();
        check("rstw_wr_off", 8'(rf_write_en), 8'd0);
        check("rstw_state", 8'(state), 8'(ST_IDLE));
        check("rstw_no_rsp", 8'(bus.rsp_valid), 8'd0);
        check("rstw_cmd_ready_low", 8'(bus.cmd_ready), 8'd0);
        rst = 1'b0;
        #1;
        check("rstw_cmd_ready", 8'(bus.cmd_ready), 8'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstw_quiet", 8'(bus.rsp_valid), 8'd0);
        end

        check("sb_empty", 8'(exp_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
